// File: rtl/vga_pkg.sv
// Shared raster-timing definitions for the VGA sync generator slice:
// phase encoding, default 640x480@60 timing and coordinate width.
package vga_pkg;

   localparam int COORD_W   = 11;
   localparam int COORD_MAX = (1 << COORD_W) - 1;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} sync_phase_t;

   // Electrical level of a sync line given whether the pulse is asserted.
   function automatic logic sync_level(input logic asserted, input logic active_low);
      return asserted ^ active_low;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// count_o is the registered position; count_next_o/phase_o expose the
// next-state values so the parent can register flags aligned to count_o.
// wrap_o is combinational and marks the step that returns the count to 0.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE_LEN = DEF_H_ACTIVE,
   parameter int FRONT_LEN  = DEF_H_FRONT,
   parameter int SYNC_LEN   = DEF_H_SYNC,
   parameter int BACK_LEN   = DEF_H_BACK
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               step_i,
   input  logic               clear_i,
   output logic [COORD_W-1:0] count_o,
   output logic [COORD_W-1:0] count_next_o,
   output logic [1:0]         phase_o,
   output logic               wrap_o
);

   localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
   localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] FRONT_AT = COORD_W'(ACTIVE_LEN);
   localparam logic [COORD_W-1:0] SYNC_AT  = COORD_W'(ACTIVE_LEN + FRONT_LEN);
   localparam logic [COORD_W-1:0] BACK_AT  = COORD_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

   logic [COORD_W-1:0] count_q, count_d;
   sync_phase_t        phase_q, phase_d;
   logic               at_last;

   // State register: position and phase.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
         phase_q <= ACTIVE;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   // Next position and phase; phase boundaries are tested on the next count.
   always_comb begin
      at_last = (count_q == LAST);
      count_d = count_q;
      phase_d = phase_q;
      if (clear_i) begin
         count_d = '0;
         phase_d = ACTIVE;
      end else if (step_i) begin
         count_d = at_last ? '0 : count_q + 1'b1;
         case (phase_q)
            ACTIVE:  if (count_d == FRONT_AT) phase_d = FRONT;
            FRONT:   if (count_d == SYNC_AT)  phase_d = SYNC;
            SYNC:    if (count_d == BACK_AT)  phase_d = BACK;
            BACK:    if (at_last)             phase_d = ACTIVE;
            default: phase_d = ACTIVE;
         endcase
      end
   end

   // Outputs: registered count, next-state views and the wrap strobe.
   always_comb begin
      count_o      = count_q;
      count_next_o = count_d;
      phase_o      = phase_d;
      wrap_o       = step_i & ~clear_i & at_last;
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel coordinates, HSYNC/VSYNC, display
// active and frame/line markers, all registered and aligned to pixelX/pixelY.
// Optional build macro VGA_SYNC_PIXDIV2_EN: internal divide-by-2 so the
// raster advances on alternate enabled clocks (pulses then last 2 clocks).
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE        = DEF_H_ACTIVE,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_ACTIVE        = DEF_V_ACTIVE,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               enable,
   output logic [COORD_W-1:0] pixelX,
   output logic [COORD_W-1:0] pixelY,
   output logic               hsync,
   output logic               vsync,
   output logic               displayActive,
   output logic               startOfFrame,
   output logic               endOfLine
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic ACT_LOW   = (SYNC_ACTIVE_LOW != 0);
   localparam logic SYNC_IDLE = sync_level(1'b0, ACT_LOW);
   localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);

   if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_chk
      $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed %0d", COORD_MAX);
   end
   if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_len_chk
      $error("vga_sync_gen: every timing parameter must be at least 1");
   end

   logic adv;

`ifdef VGA_SYNC_PIXDIV2_EN
   logic div_q, div_d;

   // Pixel-rate divider: toggles on enabled clocks, holds when frozen.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) div_q <= 1'b0;
      else         div_q <= div_d;
   end

   assign div_d = enable ? ~div_q : div_q;
   assign adv   = enable & div_q;
`else
   assign adv = enable;
`endif

   // Counters reset to 0,0 but the first advance after reset must present
   // 0,0 with startOfFrame, so that advance primes run_q instead of stepping.
   logic run_q, run_d;
   logic step;
   logic [COORD_W-1:0] h_next, v_next;
   logic [1:0] h_ph, v_ph;
   logic h_wrap, v_wrap;

   assign step = adv & run_q;

   vga_axis_counter #(
      .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT),
      .SYNC_LEN(H_SYNC),     .BACK_LEN(H_BACK)
   ) u_h (
      .clk(clk), .resetN(resetN), .step_i(step), .clear_i(1'b0),
      .count_o(pixelX), .count_next_o(h_next), .phase_o(h_ph), .wrap_o(h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT),
      .SYNC_LEN(V_SYNC),     .BACK_LEN(V_BACK)
   ) u_v (
      .clk(clk), .resetN(resetN), .step_i(h_wrap), .clear_i(1'b0),
      .count_o(pixelY), .count_next_o(v_next), .phase_o(v_ph), .wrap_o(v_wrap)
   );

   logic hsync_q, hsync_d, vsync_q, vsync_d, da_q, da_d;
   logic sof_q, sof_d, eol_q, eol_d;

   // Output flag registers, aligned with the counter registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         run_q   <= 1'b0;
         hsync_q <= SYNC_IDLE;
         vsync_q <= SYNC_IDLE;
         da_q    <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
      end else begin
         run_q   <= run_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         da_q    <= da_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
      end
   end

   // Flag next-state: decoded from the counters' next values on an advance.
   always_comb begin
      run_d   = run_q | adv;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      da_d    = da_q;
      sof_d   = sof_q;
      eol_d   = eol_q;
      if (!enable) begin
         sof_d = 1'b0;
         eol_d = 1'b0;
      end else if (adv) begin
         hsync_d = sync_level(h_ph == SYNC, ACT_LOW);
         vsync_d = sync_level(v_ph == SYNC, ACT_LOW);
         da_d    = (h_next < H_ACT_C) && (v_next < V_ACT_C);
         sof_d   = ~run_q | (h_wrap & v_wrap);
         eol_d   = (h_next == H_LAST);
      end
   end

   assign hsync         = hsync_q;
   assign vsync         = vsync_q;
   assign displayActive = da_q;
   assign startOfFrame  = sof_q;
   assign endOfLine     = eol_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that drives the pixel bus consumed by every on-screen object block.
- Produces the current pixelX/pixelY coordinates, HSYNC/VSYNC, display-active and frame/line markers.
- Sits between the pixel clock domain root and all object/drawing blocks.
- All outputs are registered and cycle-aligned to the same pixel.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses driven low, 0 = driven high

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- enable  in  1  advance raster when high; freeze all state when low
- pixelX  out  11  horizontal counter, 0..H_TOTAL-1; equals the screen column while active
- pixelY  out  11  vertical counter, 0..V_TOTAL-1; equals the screen row while active
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- displayActive  out  1  high when pixelX<H_ACTIVE and pixelY<V_ACTIVE
- startOfFrame  out  1  one-pixel pulse at pixelX=0, pixelY=0
- endOfLine  out  1  one-pixel pulse at pixelX=H_TOTAL-1

Behaviour:
- Totals:
  - H_TOTAL = sum of the four H params; V_TOTAL likewise (800 and 525 by default).
  - Both totals must be ≤2047; elaboration $error otherwise.
- Reset values:
  - pixelX=0, pixelY=0, displayActive=0, startOfFrame=0, endOfLine=0.
  - hsync and vsync at their inactive level.
  - Both phase FSMs in ACTIVE.
- Counters: on each clk edge with enable=1:
  - pixelX increments.
  - At H_TOTAL-1, pixelX wraps to 0 and pixelY increments.
  - At pixelY=V_TOTAL-1 together with pixelX=H_TOTAL-1, both wrap to 0.
- Horizontal phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - ACTIVE->FRONT when the next pixelX = H_ACTIVE.
  - FRONT->SYNC when the next pixelX = H_ACTIVE+H_FRONT.
  - SYNC->BACK when the next pixelX = H_ACTIVE+H_FRONT+H_SYNC.
  - BACK->ACTIVE on wrap.
  - The vertical FSM is identical, stepping only on the horizontal wrap.
- Sync outputs:
  - hsync is asserted exactly while the H FSM is in SYNC (default pixelX 656..751).
  - vsync is asserted while the V FSM is in SYNC (default lines 490..491).
  - vsync changes on the same cycle as the pixelX wrap.
- Alignment and latency:
  - All outputs are registered from the next-state values, so every output describes the pixel currently on pixelX/pixelY.
  - Latency from enable rising to first advance: 1 clk.
- enable=0: counters, FSMs and syncs hold; startOfFrame/endOfLine forced to 0 while frozen.
- Pulses: startOfFrame and endOfLine are 1 clk wide; a frozen raster never repeats a pulse.
- Reset mid-frame: asynchronous return to reset values; the raster restarts at 0,0 with startOfFrame high on the first enabled cycle after release.
- Zero-width porches are not supported; each parameter must be ≥1 (elaboration check).

Optional Feature:
- Macro: VGA_SYNC_PIXDIV2_EN.
- Defined:
  - Internal divide-by-2 toggle (reset 0) qualifies enable; the raster advances on alternate enabled clks (e.g. 50 MHz clk -> 25 MHz pixel rate).
  - Pulses last 2 clks.
  - Toggle holds when enable=0.
- Undefined: advance every enabled clk; no toggle register exists.

Decomposition:
- Package vga_pkg:
  - typedef enum sync_phase_t {ACTIVE, FRONT, SYNC, BACK}.
  - Default 640x480 timing localparams.
  - COORD_W=11.
- Sub-module vga_axis_counter, instanced twice:
  - Counter plus phase FSM with parameters ACTIVE/FRONT/SYNC/BACK.
  - Inputs step and clear; outputs count, phase, and wrap.
  - The horizontal instance's wrap drives the vertical instance's step.

Test Plan:
- Reset, enable=1, run 800 clks -> hsync low exactly for pixelX 656..751; endOfLine high only at pixelX=799; pixelY goes 0->1 on the next clk.
- Run a full frame (420000 clks) -> vsync low for exactly 2 lines (pixelY 490,491); startOfFrame high at clk 0 and clk 420000 only; displayActive count = 307200.
- Drop enable at pixelX=300, pixelY=10 for 50 clks -> all outputs frozen; pulses low; resume continues at pixelX=301.
- Assert resetN=0 at pixelX=700, pixelY=400 mid-hsync -> immediate pixelX=0, pixelY=0, hsync/vsync high; startOfFrame on the first clk after release.
- Parameters SYNC_ACTIVE_LOW=0, H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=1 -> H_TOTAL=14; hsync high for pixelX 10..12.
- With VGA_SYNC_PIXDIV2_EN defined -> one line takes 1600 clks; endOfLine 2 clks wide; pixelX increments every other clk.
